ccu_snoop_bcast: RTL and testbench
==================================

Name: ccu_snoop_bcast

Overview:
- Snoop-side counterpart of the CCU request dispatcher: the CCU control logic hands it one snoop request, targeting the line a requesting port wants.
- Broadcasts the snoop on the AC channel to every port except the initiator and collects each target's CR response.
- Returns the aggregated snoop response, then the CD data from the first supplier, to the CCU.
- One snoop outstanding at a time; sits between the CCU FSM and the per-core ACE snoop channels.

Parameters:
- NoPorts, 4, number of cached master ports (>=2).
- AxiAddrWidth, 64, AC address width.
- DataWidth, 64, CD data width.
- IdxW, $clog2(NoPorts), initiator index width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- snp_valid_i  in  1  snoop request valid.
- snp_ready_o  out  1  snoop request accepted.
- snp_addr_i  in  AxiAddrWidth  snoop address.
- snp_snoop_i  in  4  ACSNOOP code.
- snp_prot_i  in  3  ACPROT.
- snp_initiator_i  in  IdxW  port excluded from broadcast.
- ac_valid_o  out  NoPorts  per-port AC valid.
- ac_ready_i  in  NoPorts  per-port AC ready.
- ac_addr_o  out  AxiAddrWidth  shared AC address.
- ac_snoop_o  out  4  shared AC snoop code.
- ac_prot_o  out  3  shared AC prot.
- cr_valid_i  in  NoPorts  per-port CR valid.
- cr_ready_o  out  NoPorts  per-port CR ready.
- cr_resp_i  in  NoPorts*5  per-port CRRESP: bit0 DataTransfer, bit1 Error, bit2 PassDirty, bit3 IsShared, bit4 WasUnique.
- cd_valid_i  in  NoPorts  per-port CD valid.
- cd_ready_o  out  NoPorts  per-port CD ready.
- cd_data_i  in  NoPorts*DataWidth  per-port CD data.
- cd_last_i  in  NoPorts  per-port CD last.
- rsp_valid_o  out  1  aggregated response valid.
- rsp_ready_i  in  1  aggregated response ready.
- rsp_resp_o  out  5  aggregated CRRESP.
- data_valid_o  out  1  forwarded CD valid.
- data_ready_i  in  1  forwarded CD ready.
- data_o  out  DataWidth  forwarded CD data.
- data_last_o  out  1  forwarded CD last.

Behaviour:
- Reset (async, any state): FSM returns to IDLE and all per-port tracking masks clear. All valid and ready outputs are 0 except snp_ready_o, which is 1. ac_addr_o, ac_snoop_o, ac_prot_o, rsp_resp_o and data_o reset to 0.
- States and transitions:
  - IDLE: snp_ready_o=1. On snp_valid_i, register addr, snoop, prot and initiator. Set ac_pend = cr_pend = all ones except bit[initiator]; clear the aggregate register; go to SNOOP. If ac_pend is empty (initiator-only case), go directly to RESP.
  - SNOOP: snp_ready_o=0. ac_valid_o = ac_pend.
    - A port's bit in ac_pend clears on ac_valid_o&ac_ready_i. Each port completes independently; ac_valid_o never drops before its handshake.
    - cr_ready_o = cr_pend & ~ac_pend: CR is never accepted before that port's AC handshake.
    - On each CR handshake: clear the cr_pend bit, OR the response into the aggregate (bits 1..4), and set dt_mask[port] if DataTransfer.
    - Leave for RESP on the cycle cr_pend becomes zero, registered: rsp_valid_o rises on the following cycle.
  - RESP: rsp_valid_o=1. rsp_resp_o = aggregate, with bit0 = |dt_mask. rsp_resp_o is held stable until rsp_ready_i. After the handshake, go to DATA if dt_mask is nonzero, else IDLE.
  - DATA:
    - src = lowest set index of dt_mask.
    - data_valid_o/data_o/data_last_o = cd_*[src]; cd_ready_o[src] = data_ready_i.
    - Every other dt_mask port has cd_ready_o=1; its data is drained and discarded.
    - A port's dt_mask bit clears on its handshake with cd_last_i. src is frozen at DATA entry.
    - Go to IDLE when dt_mask becomes zero.
- cd_ready_o=0 outside DATA. CD beats arriving early stall at the core.
- Ports without DataTransfer never see cd_ready_o asserted.
- Latency: snp handshake at cycle 0 gives ac_valid_o at cycle 1. With all targets ready and responding immediately, rsp_valid_o at cycle 3.
- Simultaneous AC and CR handshake on the same port in the same cycle is impossible by the cr_ready gating.
- Simultaneous CRs from several ports are all accepted in one cycle and OR-combined.
- Error bit is OR of all targets; DATA is still entered if any DataTransfer is set.
- snp_initiator_i >= NoPorts: no port is excluded (all snooped).
- AC payload outputs hold the registered values from acceptance until IDLE.

Test Plan:
- NoPorts=4, initiator=0, all ac_ready/cr_valid=1, all CR=0 -> ac_valid_o=4'b1110 for one cycle; rsp_valid_o at cycle 3, rsp_resp_o=0; back to IDLE, no DATA.
- Port 2 CR=5'b01101 (DT, PassDirty, IsShared), 4-beat CD 0xA0..0xA3; others CR=0 -> rsp_resp_o=5'b01101; data_o sequence A0,A1,A2,A3 with data_last_o only on beat 4.
- Ports 1 and 3 both DataTransfer -> port 1 data forwarded; port 3 CD drained with cd_ready_o[3]=1, none forwarded; IDLE only after both last beats.
- ac_ready_i[3] delayed 5 cycles, cr_valid_i[3] asserted early -> cr_ready_o[3] stays 0 until the AC handshake; ac_valid_o[1..2] drop after their own handshakes; rsp delayed accordingly.
- rsp_ready_i and data_ready_i held low 3 cycles -> rsp_resp_o and data_o stable; no CD handshake occurs.
- rst_ni pulsed low during DATA mid-burst -> all valids and readies are 0 immediately; snp_ready_o=1 after release; next snoop completes normally.

Source files
------------

// File: rtl/ccu_snoop_bcast.sv
// Snoop broadcaster for the CCU: fans one snoop out on the AC channels, merges the
// CR responses, then forwards CD data from the lowest-indexed supplier.
module ccu_snoop_bcast #(
    parameter int NoPorts      = 4,
    parameter int AxiAddrWidth = 64,
    parameter int DataWidth    = 64,
    parameter int IdxW         = $clog2(NoPorts)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         snp_valid_i,
    output logic                         snp_ready_o,
    input  logic [AxiAddrWidth-1:0]      snp_addr_i,
    input  logic [3:0]                   snp_snoop_i,
    input  logic [2:0]                   snp_prot_i,
    input  logic [IdxW-1:0]              snp_initiator_i,
    output logic [NoPorts-1:0]           ac_valid_o,
    input  logic [NoPorts-1:0]           ac_ready_i,
    output logic [AxiAddrWidth-1:0]      ac_addr_o,
    output logic [3:0]                   ac_snoop_o,
    output logic [2:0]                   ac_prot_o,
    input  logic [NoPorts-1:0]           cr_valid_i,
    output logic [NoPorts-1:0]           cr_ready_o,
    input  logic [NoPorts*5-1:0]         cr_resp_i,
    input  logic [NoPorts-1:0]           cd_valid_i,
    output logic [NoPorts-1:0]           cd_ready_o,
    input  logic [NoPorts*DataWidth-1:0] cd_data_i,
    input  logic [NoPorts-1:0]           cd_last_i,
    output logic                         rsp_valid_o,
    input  logic                         rsp_ready_i,
    output logic [4:0]                   rsp_resp_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic [DataWidth-1:0]         data_o,
    output logic                         data_last_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SNOOP = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;
    localparam logic [1:0] DATA  = 2'd3;

    logic [1:0]              state_q;
    logic [AxiAddrWidth-1:0] addr_q;
    logic [3:0]              snoop_q;
    logic [2:0]              prot_q;
    logic [NoPorts-1:0]      ac_pend_q;
    logic [NoPorts-1:0]      cr_pend_q;
    logic [NoPorts-1:0]      dt_mask_q;
    logic [3:0]              agg_q;
    logic [IdxW-1:0]         src_q;

    logic [NoPorts-1:0]      target_mask;
    logic [NoPorts-1:0]      ac_hs;
    logic [NoPorts-1:0]      cr_hs;
    logic [NoPorts-1:0]      cd_last_hs;
    logic [NoPorts-1:0]      cr_dt;
    logic [3:0]              cr_or;
    logic [IdxW-1:0]         first_dt;
    logic [NoPorts-1:0]      cr_pend_next;
    logic [NoPorts-1:0]      dt_mask_next;

    // An out-of-range initiator matches no bit, so every port is snooped.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        target_mask = '1;
        for (int i = 0; i < NoPorts; i++) begin
            if (int'(snp_initiator_i) == i) target_mask[i] = 1'b0;
        end
    end

    always_comb begin
        cr_or = '0;
        cr_dt = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (cr_hs[i]) begin
                cr_or    = cr_or | cr_resp_i[i*5+1 +: 4];
                cr_dt[i] = cr_resp_i[i*5];
            end
        end
    end

    always_comb begin
        first_dt = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (dt_mask_q[i]) first_dt = IdxW'(i);
        end
    end

    assign snp_ready_o = (state_q == IDLE);
    assign ac_valid_o  = (state_q == SNOOP) ? ac_pend_q : '0;
    assign cr_ready_o  = (state_q == SNOOP) ? (cr_pend_q & ~ac_pend_q) : '0;
    assign ac_addr_o   = addr_q;
    assign ac_snoop_o  = snoop_q;
    assign ac_prot_o   = prot_q;

    assign rsp_valid_o = (state_q == RESP);
    assign rsp_resp_o  = (state_q == RESP) ? {agg_q, |dt_mask_q} : 5'd0;

    // The frozen source stops presenting once its own last beat has gone.
    assign data_valid_o = (state_q == DATA) && dt_mask_q[src_q] && cd_valid_i[src_q];
    assign data_o       = (state_q == DATA) ? cd_data_i[int'(src_q)*DataWidth +: DataWidth] : '0;
    assign data_last_o  = (state_q == DATA) && cd_last_i[src_q];

    always_comb begin
        cd_ready_o = '0;
        if (state_q == DATA) begin
            cd_ready_o         = dt_mask_q;
            cd_ready_o[src_q]  = dt_mask_q[src_q] & data_ready_i;
        end
    end

    assign ac_hs        = ac_valid_o & ac_ready_i;
    assign cr_hs        = cr_ready_o & cr_valid_i;
    assign cd_last_hs   = cd_ready_o & cd_valid_i & cd_last_i;
    assign cr_pend_next = cr_pend_q & ~cr_hs;
    assign dt_mask_next = dt_mask_q & ~cd_last_hs;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            snoop_q   <= '0;
            prot_q    <= '0;
            ac_pend_q <= '0;
            cr_pend_q <= '0;
            dt_mask_q <= '0;
            agg_q     <= '0;
            src_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snp_valid_i) begin
                        addr_q    <= snp_addr_i;
                        snoop_q   <= snp_snoop_i;
                        prot_q    <= snp_prot_i;
                        ac_pend_q <= target_mask;
                        cr_pend_q <= target_mask;
                        dt_mask_q <= '0;
                        agg_q     <= '0;
                        state_q   <= (target_mask == '0) ? RESP : SNOOP;
                    end
                end
                SNOOP: begin
                    ac_pend_q <= ac_pend_q & ~ac_hs;
                    cr_pend_q <= cr_pend_next;
                    agg_q     <= agg_q | cr_or;
                    dt_mask_q <= dt_mask_q | cr_dt;
                    if (cr_pend_next == '0) state_q <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        src_q   <= first_dt;
                        state_q <= (dt_mask_q != '0) ? DATA : IDLE;
                    end
                end
                default: begin
                    dt_mask_q <= dt_mask_next;
                    if (dt_mask_next == '0) state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// Self-checking bench for ccu_snoop_bcast: a per-cycle core model drives AC/CR/CD,
// and a scoreboard holds the expected aggregated response and forwarded beats.
module tb_ccu_snoop_bcast;

    localparam int NP = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int IW = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              snp_valid_i;
    logic              snp_ready_o;
    logic [AW-1:0]     snp_addr_i;
    logic [3:0]        snp_snoop_i;
    logic [2:0]        snp_prot_i;
    logic [IW-1:0]     snp_initiator_i;
    logic [NP-1:0]     ac_valid_o;
    logic [NP-1:0]     ac_ready_i;
    logic [AW-1:0]     ac_addr_o;
    logic [3:0]        ac_snoop_o;
    logic [2:0]        ac_prot_o;
    logic [NP-1:0]     cr_valid_i;
    logic [NP-1:0]     cr_ready_o;
    logic [NP*5-1:0]   cr_resp_i;
    logic [NP-1:0]     cd_valid_i;
    logic [NP-1:0]     cd_ready_o;
    logic [NP*DW-1:0]  cd_data_i;
    logic [NP-1:0]     cd_last_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [4:0]        rsp_resp_o;
    logic              data_valid_o;
    logic              data_ready_i;
    logic [DW-1:0]     data_o;
    logic              data_last_o;

    always #5 clk_i = ~clk_i;

    ccu_snoop_bcast #(.NoPorts(NP), .AxiAddrWidth(AW), .DataWidth(DW), .IdxW(IW)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .snp_valid_i(snp_valid_i), .snp_ready_o(snp_ready_o), .snp_addr_i(snp_addr_i),
        .snp_snoop_i(snp_snoop_i), .snp_prot_i(snp_prot_i), .snp_initiator_i(snp_initiator_i),
        .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
        .ac_snoop_o(ac_snoop_o), .ac_prot_o(ac_prot_o),
        .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
        .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
        .cd_last_i(cd_last_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_resp_o(rsp_resp_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
        .data_last_o(data_last_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: aggregated responses and {last, data} beats expected on the forward port.
    logic [4:0]  exp_rsp_q[$];
    logic [DW:0] exp_data_q[$];

    // Core model configuration, one entry per port.
    logic [4:0]    cfg_cr[NP];
    int            cfg_ac_delay[NP];
    bit            cfg_cr_early[NP];
    int            cfg_beats[NP];
    logic [DW-1:0] cfg_base[NP];
    int            cfg_rsp_stall;
    int            cfg_data_stall;
    int            cfg_abort_beats;

    // Per-transaction observations.
    int first_ac_cyc, ac_cycles, first_rsp_cyc, rsp_hs_cyc, fwd_count;

    task automatic clear_cfg();
        for (int p = 0; p < NP; p++) begin
            cfg_cr[p] = 5'd0; cfg_ac_delay[p] = 0; cfg_cr_early[p] = 1'b0;
            cfg_beats[p] = 0; cfg_base[p] = '0;
        end
        cfg_rsp_stall = 0; cfg_data_stall = 0; cfg_abort_beats = 0;
    endtask

    task automatic idle_inputs();
        snp_valid_i = 1'b0; ac_ready_i = '0; cr_valid_i = '0; cr_resp_i = '0;
        cd_valid_i = '0; cd_data_i = '0; cd_last_i = '0; rsp_ready_i = 1'b0; data_ready_i = 1'b0;
    endtask

    task automatic run_snoop(input logic [IW-1:0] init, input logic [AW-1:0] addr,
                             input logic [3:0] snoop, input logic [2:0] prot);
        logic [NP-1:0] target, ac_done, cr_done, dt, exp_cd_ready;
        logic [4:0]    exp_r, held_rsp;
        logic [DW:0]   held_data, got;
        int            beat[NP];
        int            src, cyc, rsp_wait, data_wait;
        bit            rsp_done, hold_rsp, hold_data, all_cr, done_all;

        target = '1; target[init] = 1'b0;
        ac_done = '0; cr_done = '0; dt = '0; exp_r = 5'd0; src = -1;
        rsp_done = 0; hold_rsp = 0; hold_data = 0; rsp_wait = 0; data_wait = 0;
        held_rsp = '0; held_data = '0;
        first_ac_cyc = -1; ac_cycles = 0; first_rsp_cyc = -1; rsp_hs_cyc = -1; fwd_count = 0;
        for (int p = 0; p < NP; p++) begin
            beat[p] = 0;
            if (target[p]) begin
                exp_r[4:1] = exp_r[4:1] | cfg_cr[p][4:1];
                dt[p] = cfg_cr[p][0];
            end
        end
        exp_r[0] = |dt;
        exp_rsp_q.push_back(exp_r);
        for (int p = NP - 1; p >= 0; p--) if (dt[p]) src = p;
        if (src >= 0)
            for (int b = 0; b < cfg_beats[src]; b++)
                exp_data_q.push_back({b == cfg_beats[src] - 1, cfg_base[src] + DW'(b)});

        @(negedge clk_i);
        snp_valid_i = 1'b1; snp_addr_i = addr; snp_snoop_i = snoop;
        snp_prot_i = prot; snp_initiator_i = init;
        #1;
        n_checks++;
        if (snp_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL snp_ready_idle: got %b want 1", snp_ready_o);
        end
        @(posedge clk_i);
        cyc = 1;
        while (cyc < 300) begin
            @(negedge clk_i);
            snp_valid_i = 1'b0;
            for (int p = 0; p < NP; p++) begin
                ac_ready_i[p] = (cyc >= cfg_ac_delay[p]);
                cr_valid_i[p] = target[p] && !cr_done[p] && (ac_done[p] || cfg_cr_early[p]);
                cr_resp_i[p*5 +: 5] = cfg_cr[p];
                cd_valid_i[p] = target[p] && cr_done[p] && cfg_cr[p][0] && (beat[p] < cfg_beats[p]);
                cd_data_i[p*DW +: DW] = cfg_base[p] + DW'(beat[p]);
                cd_last_i[p] = (beat[p] == cfg_beats[p] - 1);
            end
            #1;
            rsp_ready_i  = rsp_valid_o && (rsp_wait >= cfg_rsp_stall);
            data_ready_i = data_valid_o && (data_wait >= cfg_data_stall);
            #1;

            if (cfg_abort_beats > 0 && fwd_count >= cfg_abort_beats) begin
                rst_ni = 1'b0;
                #1;
                n_checks++;
                if ({ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o, data_valid_o, snp_ready_o}
                    !== {{(3*NP+2){1'b0}}, 1'b1}) begin
                    n_fail++;
                    $display("FAIL reset_mid_burst_hs: ac_v=%b cr_r=%b cd_r=%b rsp_v=%b dat_v=%b snp_r=%b",
                             ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o, data_valid_o, snp_ready_o);
                end
                n_checks++;
                if ({ac_addr_o, rsp_resp_o, data_o} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_mid_burst_payload: addr=%h resp=%b data=%h want 0",
                             ac_addr_o, rsp_resp_o, data_o);
                end
                idle_inputs();
                @(posedge clk_i);
                @(negedge clk_i);
                rst_ni = 1'b1;
                #1;
                n_checks++;
                if (snp_ready_o !== 1'b1) begin
                    n_fail++; $display("FAIL reset_release_snp_ready: got %b want 1", snp_ready_o);
                end
                exp_rsp_q.delete();
                exp_data_q.delete();
                return;
            end

            all_cr = &(cr_done | ~target);
            done_all = rsp_done;
            for (int p = 0; p < NP; p++) if (dt[p] && beat[p] < cfg_beats[p]) done_all = 0;
            for (int p = 0; p < NP; p++)
                exp_cd_ready[p] = (rsp_done && dt[p] && beat[p] < cfg_beats[p])
                                  ? ((p == src) ? data_ready_i : 1'b1) : 1'b0;

            n_checks++;
            if (ac_valid_o !== (target & ~ac_done)) begin
                n_fail++; $display("FAIL ac_valid cyc%0d: got %b want %b", cyc, ac_valid_o, target & ~ac_done);
            end
            n_checks++;
            if (cr_ready_o !== (target & ac_done & ~cr_done)) begin
                n_fail++;
                $display("FAIL cr_ready cyc%0d: got %b want %b", cyc, cr_ready_o, target & ac_done & ~cr_done);
            end
            n_checks++;
            if (rsp_valid_o !== (all_cr && !rsp_done)) begin
                n_fail++; $display("FAIL rsp_valid cyc%0d: got %b want %b", cyc, rsp_valid_o, all_cr && !rsp_done);
            end
            n_checks++;
            if (cd_ready_o !== exp_cd_ready) begin
                n_fail++; $display("FAIL cd_ready cyc%0d: got %b want %b", cyc, cd_ready_o, exp_cd_ready);
            end
            n_checks++;
            if (snp_ready_o !== done_all) begin
                n_fail++; $display("FAIL snp_ready cyc%0d: got %b want %b", cyc, snp_ready_o, done_all);
            end
            if (ac_valid_o != '0) begin
                n_checks++;
                if ({ac_addr_o, ac_snoop_o, ac_prot_o} !== {addr, snoop, prot}) begin
                    n_fail++;
                    $display("FAIL ac_payload cyc%0d: got %h/%h/%h want %h/%h/%h",
                             cyc, ac_addr_o, ac_snoop_o, ac_prot_o, addr, snoop, prot);
                end
            end
            if (hold_rsp) begin
                n_checks++;
                if ({rsp_valid_o, rsp_resp_o} !== {1'b1, held_rsp}) begin
                    n_fail++;
                    $display("FAIL rsp_stable cyc%0d: got %b/%b want 1/%b", cyc, rsp_valid_o, rsp_resp_o, held_rsp);
                end
            end
            if (hold_data) begin
                n_checks++;
                if ({data_valid_o, data_last_o, data_o} !== {1'b1, held_data}) begin
                    n_fail++;
                    $display("FAIL data_stable cyc%0d: got %b/%h want 1/%h", cyc, data_valid_o,
                             {data_last_o, data_o}, held_data);
                end
            end
            if (done_all) break;

            if (ac_valid_o != '0) begin
                if (first_ac_cyc < 0) first_ac_cyc = cyc;
                ac_cycles++;
            end
            if (rsp_valid_o && first_rsp_cyc < 0) first_rsp_cyc = cyc;

            if (rsp_valid_o && rsp_ready_i) begin
                n_checks++;
                if (exp_rsp_q.size() == 0) begin
                    n_fail++; $display("FAIL rsp_unexpected cyc%0d: got %b", cyc, rsp_resp_o);
                end else begin
                    exp_r = exp_rsp_q.pop_front();
                    if (rsp_resp_o !== exp_r) begin
                        n_fail++; $display("FAIL rsp_resp cyc%0d: got %b want %b", cyc, rsp_resp_o, exp_r);
                    end
                end
                rsp_done = 1; rsp_hs_cyc = cyc;
            end else if (rsp_valid_o) begin
                rsp_wait++;
            end
            hold_rsp = rsp_valid_o && !rsp_ready_i;
            held_rsp = rsp_resp_o;

            if (data_valid_o && data_ready_i) begin
                got = {data_last_o, data_o};
                n_checks++;
                if (exp_data_q.size() == 0) begin
                    n_fail++; $display("FAIL data_unexpected cyc%0d: got %h", cyc, got);
                end else begin
                    held_data = exp_data_q.pop_front();
                    if (got !== held_data) begin
                        n_fail++; $display("FAIL data_beat cyc%0d: got %h want %h", cyc, got, held_data);
                    end
                end
                fwd_count++;
            end else if (data_valid_o) begin
                data_wait++;
            end
            hold_data = data_valid_o && !data_ready_i;
            held_data = {data_last_o, data_o};

            for (int p = 0; p < NP; p++) begin
                if (ac_valid_o[p] && ac_ready_i[p]) ac_done[p] = 1'b1;
                if (cr_valid_i[p] && cr_ready_o[p]) cr_done[p] = 1'b1;
                if (cd_valid_i[p] && cd_ready_o[p]) beat[p]++;
            end
            @(posedge clk_i);
            cyc++;
        end
        n_checks++;
        if (cyc >= 300) begin
            n_fail++; $display("FAIL timeout: snoop did not complete in 300 cycles");
        end
        n_checks++;
        if (exp_rsp_q.size() + exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: got %0d rsp %0d beats pending want 0 0",
                     exp_rsp_q.size(), exp_data_q.size());
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        snp_addr_i = '0; snp_snoop_i = '0; snp_prot_i = '0; snp_initiator_i = '0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_checks++;
        if ({snp_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o, data_valid_o}
            !== {1'b1, {(3*NP+2){1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_hs: snp_r=%b ac_v=%b cr_r=%b cd_r=%b rsp_v=%b dat_v=%b",
                     snp_ready_o, ac_valid_o, cr_ready_o, cd_ready_o, rsp_valid_o, data_valid_o);
        end
        n_checks++;
        if ({ac_addr_o, ac_snoop_o, ac_prot_o, rsp_resp_o, data_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_payload: addr=%h snoop=%h prot=%h resp=%b data=%h want 0",
                     ac_addr_o, ac_snoop_o, ac_prot_o, rsp_resp_o, data_o);
        end
        rst_ni = 1'b1;
    endtask

    task automatic test_broadcast();
        clear_cfg();
        run_snoop(2'd0, 64'h0000_1234_5678_9ac0, 4'h1, 3'h2);
        n_checks++;
        if ({first_ac_cyc, ac_cycles, first_rsp_cyc, fwd_count} !== {32'sd1, 32'sd1, 32'sd3, 32'sd0}) begin
            n_fail++;
            $display("FAIL broadcast_timing: ac@%0d x%0d rsp@%0d beats %0d want ac@1 x1 rsp@3 beats 0",
                     first_ac_cyc, ac_cycles, first_rsp_cyc, fwd_count);
        end
    endtask

    task automatic test_single_supplier();
        clear_cfg();
        cfg_cr[2] = 5'b01101; cfg_beats[2] = 4; cfg_base[2] = 64'hA0;
        run_snoop(2'd0, 64'hdead_beef_0000_0040, 4'h7, 3'h0);
        n_checks++;
        if (fwd_count !== 4) begin
            n_fail++; $display("FAIL single_supplier_beats: got %0d want 4", fwd_count);
        end
    endtask

    task automatic test_two_suppliers();
        clear_cfg();
        cfg_cr[1] = 5'b00001; cfg_beats[1] = 2; cfg_base[1] = 64'hB0;
        cfg_cr[3] = 5'b01001; cfg_beats[3] = 3; cfg_base[3] = 64'hC0;
        run_snoop(2'd0, 64'h80, 4'h9, 3'h1);
        n_checks++;
        if (fwd_count !== 2) begin
            n_fail++; $display("FAIL two_suppliers_beats: got %0d want 2", fwd_count);
        end
    endtask

    task automatic test_error_or();
        clear_cfg();
        cfg_cr[0] = 5'b10000;
        cfg_cr[3] = 5'b00011; cfg_beats[3] = 1; cfg_base[3] = 64'hE0;
        run_snoop(2'd1, 64'h1000, 4'hB, 3'h3);
    endtask

    task automatic test_ac_delay();
        clear_cfg();
        cfg_ac_delay[3] = 5; cfg_cr_early[3] = 1'b1; cfg_cr[1] = 5'b01000;
        run_snoop(2'd2, 64'h2000, 4'h1, 3'h0);
        n_checks++;
        if (first_rsp_cyc !== 7) begin
            n_fail++; $display("FAIL ac_delay_rsp_cycle: got %0d want 7", first_rsp_cyc);
        end
    endtask

    task automatic test_stall();
        clear_cfg();
        cfg_rsp_stall = 3; cfg_data_stall = 3;
        cfg_cr[1] = 5'b00101; cfg_beats[1] = 2; cfg_base[1] = 64'h55;
        run_snoop(2'd3, 64'h3000, 4'h7, 3'h0);
        n_checks++;
        if (rsp_hs_cyc - first_rsp_cyc !== 3) begin
            n_fail++; $display("FAIL stall_rsp_wait: got %0d cycles want 3", rsp_hs_cyc - first_rsp_cyc);
        end
    endtask

    task automatic test_reset_mid_burst();
        clear_cfg();
        cfg_cr[2] = 5'b00001; cfg_beats[2] = 4; cfg_base[2] = 64'h70;
        cfg_abort_beats = 2;
        run_snoop(2'd0, 64'h4000, 4'h1, 3'h0);
    endtask

    task automatic test_after_reset();
        clear_cfg();
        cfg_cr[1] = 5'b00001; cfg_beats[1] = 1; cfg_base[1] = 64'h99;
        run_snoop(2'd0, 64'h5000, 4'h1, 3'h0);
        n_checks++;
        if (fwd_count !== 1) begin
            n_fail++; $display("FAIL after_reset_beats: got %0d want 1", fwd_count);
        end
    endtask

    initial begin
        test_reset();
        test_broadcast();
        test_single_supplier();
        test_two_suppliers();
        test_error_or();
        test_ac_delay();
        test_stall();
        test_reset_mid_burst();
        test_after_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
